sprite_renderer: RTL

Pixel-generation stage directly downstream of the VGA timing generator. Consumes its `hCount`, `vCount`, `bright` and sync outputs on the 100 MHz system clock. Draws a square player sprite on a solid background and moves it once per frame from four push-buttons, flashing the screen border when the sprite hits an edge. Emits 12-bit RGB plus delayed syncs, all aligned to the same pipeline latency, for the VGA pins.

---
 rtl/vga_pkg.sv | 18 +
 rtl/sprite_renderer_if.sv | 23 ++
 rtl/sprite_motion.sv | 119 +++++++++++
 rtl/sprite_renderer.sv | 97 +++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pixel type and motion FSM encoding for the sprite renderer.
package vga_pkg;

    localparam int unsigned H_ACTIVE_START = 144;
    localparam int unsigned V_ACTIVE_START = 35;
    localparam int unsigned ACTIVE_W       = 640;
    localparam int unsigned ACTIVE_H       = 480;
    localparam int unsigned V_BLANK_TICK   = 516;
    localparam int unsigned RGB_W          = 12;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic {
        StWait,
        StUpdate
    } motion_state_e;

endpackage

// File: rtl/sprite_renderer_if.sv
// Video bundle between the timing generator, the sprite renderer and the VGA pins.
interface sprite_renderer_if;

    logic [9:0]                hCount;
    logic [9:0]                vCount;
    logic                      bright;
    logic                      hSync_in;
    logic                      vSync_in;
    logic [vga_pkg::RGB_W-1:0] rgb;
    logic                      hSync_out;
    logic                      vSync_out;

    modport master (
        output hCount, vCount, bright, hSync_in, vSync_in,
        input  rgb, hSync_out, vSync_out
    );

    modport slave (
        input  hCount, vCount, bright, hSync_in, vSync_in,
        output rgb, hSync_out, vSync_out
    );

endinterface

// File: rtl/sprite_motion.sv
// Button sync, once-per-frame tick, and clamped sprite motion with a border-flash counter.
module sprite_motion import vga_pkg::*; #(
    parameter int unsigned SPRITE_SIZE  = 32,
    parameter int unsigned STEP         = 4,
    parameter int unsigned X_INIT       = 304,
    parameter int unsigned Y_INIT       = 224,
    parameter int unsigned FLASH_FRAMES = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] v_s1,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       hit
);

    localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [9:0] STEP_V = 10'(STEP);
    localparam logic [9:0] X_MAX  = 10'(ACTIVE_W - SPRITE_SIZE);
    localparam logic [9:0] Y_MAX  = 10'(ACTIVE_H - SPRITE_SIZE);
    localparam logic [9:0] TICK_V = 10'(V_BLANK_TICK);

    // Button vectors are {up, down, left, right}.
    logic [3:0]    sync1_q, sync2_q, btn_q, btn_d;
    logic [9:0]    v_prev_q, x_q, x_d, y_q, y_d;
    logic [FW-1:0] flash_q, flash_d;
    motion_state_e state_q, state_d;
    logic          tick, clamp;

    assign tick = (v_s1 == TICK_V) && (v_prev_q != TICK_V);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            btn_q    <= '0;
            v_prev_q <= '0;
            x_q      <= 10'(X_INIT);
            y_q      <= 10'(Y_INIT);
            flash_q  <= '0;
            state_q  <= StWait;
        end else begin
            sync1_q  <= {btn_up, btn_down, btn_left, btn_right};
            sync2_q  <= sync1_q;
            btn_q    <= btn_d;
            v_prev_q <= v_s1;
            x_q      <= x_d;
            y_q      <= y_d;
            flash_q  <= flash_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        btn_d   = btn_q;
        x_d     = x_q;
        y_d     = y_q;
        flash_d = flash_q;
        clamp   = 1'b0;
        case (state_q)
            StWait: begin
                // Buttons are frozen at the tick so a late change waits for the next frame.
                if (tick) begin
                    state_d = StUpdate;
                    btn_d   = sync2_q;
                end
            end
            StUpdate: begin
                state_d = StWait;
                if (btn_q[1] && !btn_q[0]) begin
                    if (x_q < STEP_V) begin
                        x_d   = '0;
                        clamp = 1'b1;
                    end else begin
                        x_d = x_q - STEP_V;
                    end
                end else if (btn_q[0] && !btn_q[1]) begin
                    if (x_q > X_MAX - STEP_V) begin
                        x_d   = X_MAX;
                        clamp = 1'b1;
                    end else begin
                        x_d = x_q + STEP_V;
                    end
                end
                if (btn_q[3] && !btn_q[2]) begin
                    if (y_q < STEP_V) begin
                        y_d   = '0;
                        clamp = 1'b1;
                    end else begin
                        y_d = y_q - STEP_V;
                    end
                end else if (btn_q[2] && !btn_q[3]) begin
                    if (y_q > Y_MAX - STEP_V) begin
                        y_d   = Y_MAX;
                        clamp = 1'b1;
                    end else begin
                        y_d = y_q + STEP_V;
                    end
                end
                if (clamp) begin
                    flash_d = FW'(FLASH_FRAMES);
                end else if (flash_q != '0) begin
                    flash_d = flash_q - 1'b1;
                end
            end
            default: state_d = StWait;
        endcase
    end

    assign sprite_x = x_q;
    assign sprite_y = y_q;
    assign hit      = (flash_q != '0);

endmodule

// File: rtl/sprite_renderer.sv
// Two-stage pixel pipeline drawing a movable square sprite with a flashing border on hits.
module sprite_renderer import vga_pkg::*; #(
    parameter int unsigned SPRITE_SIZE  = 32,
    parameter int unsigned STEP         = 4,
    parameter int unsigned X_INIT       = 304,
    parameter int unsigned Y_INIT       = 224,
    parameter int unsigned BORDER_W     = 4,
    parameter int unsigned FLASH_FRAMES = 15,
    parameter rgb_t        COLOR_SPRITE = 12'hF00,
    parameter rgb_t        COLOR_BG     = 12'h000,
    parameter rgb_t        COLOR_FLASH  = 12'hFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    sprite_renderer_if.slave  vid,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    output logic [9:0]        sprite_x,
    output logic [9:0]        sprite_y,
    output logic              hit
);

    logic [9:0] h_q, v_q, px, py;
    logic       bright_q, hs_q, vs_q, hs2_q, vs2_q;
    rgb_t       rgb_q, rgb_d;
    logic       in_sprite, in_border;

    sprite_motion #(
        .SPRITE_SIZE  (SPRITE_SIZE),
        .STEP         (STEP),
        .X_INIT       (X_INIT),
        .Y_INIT       (Y_INIT),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_motion (
        .clk       (clk),
        .reset_n   (reset_n),
        .v_s1      (v_q),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .hit       (hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q      <= '0;
            v_q      <= '0;
            bright_q <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            rgb_q    <= '0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
        end else begin
            h_q      <= vid.hCount;
            v_q      <= vid.vCount;
            bright_q <= vid.bright;
            hs_q     <= vid.hSync_in;
            vs_q     <= vid.vSync_in;
            rgb_q    <= rgb_d;
            hs2_q    <= hs_q;
            vs2_q    <= vs_q;
        end
    end

    // Wraps outside active video, but the result is only used when bright is set.
    assign px = h_q - 10'(H_ACTIVE_START);
    assign py = v_q - 10'(V_ACTIVE_START);

    assign in_sprite = (px >= sprite_x) && ({1'b0, px} < {1'b0, sprite_x} + 11'(SPRITE_SIZE)) &&
                       (py >= sprite_y) && ({1'b0, py} < {1'b0, sprite_y} + 11'(SPRITE_SIZE));
    assign in_border = (px < 10'(BORDER_W)) || (px >= 10'(ACTIVE_W - BORDER_W)) ||
                       (py < 10'(BORDER_W)) || (py >= 10'(ACTIVE_H - BORDER_W));

    always_comb begin
        rgb_d = '0;
        if (bright_q) begin
            if (in_sprite) begin
                rgb_d = COLOR_SPRITE;
            end else if (hit && in_border) begin
                rgb_d = COLOR_FLASH;
            end else begin
                rgb_d = COLOR_BG;
            end
        end
    end

    assign vid.rgb       = rgb_q;
    assign vid.hSync_out = hs2_q;
    assign vid.vSync_out = vs2_q;

endmodule
